// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-RAM boot sequencer: state encoding,
// default RAM geometry and checksum width.
package imem_boot_ctrl_pkg;

    localparam int IMEM_DEPTH  = 128;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);
    localparam int IMEM_DATA_W = 32;
    localparam int CSUM_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl_req_edge_det.sv
// Rising/falling edge detector for a level request, using one history register.
// Edges are decoded combinationally against the registered previous level.
module req_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise,
    output logic fall
);

    logic req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req;
        end
    end

    assign rise = req & ~req_q;
    assign fall = ~req & req_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program image into the instruction RAM, keeps a
// running checksum and holds the core in reset-PC until the image is complete.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic [CSUM_W-1:0] checksum,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    boot_state_t state, next_state;
    logic        load_req_rise;
    logic        load_req_fall;
    logic        transfer;
    logic        load_start;

    req_edge_det u_req_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (load_req),
        .rise  (load_req_rise),
        .fall  (load_req_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // LOAD is only entered on a rising edge, so a falling edge there is
    // exactly the "request withdrawn" abort condition.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (load_req_rise) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_req_fall) begin
                    next_state = ST_IDLE;
                end else if (ld_valid && ld_last) begin
                    next_state = ST_SETTLE;
                end else if (ld_valid && (word_cnt == CNT_LAST)) begin
                    next_state = ST_ERR;
                end
            end
            ST_SETTLE: next_state = ST_RUN;
            ST_RUN: begin
                if (load_req_rise) next_state = ST_LOAD;
            end
            ST_ERR: begin
                if (load_req_rise) next_state = ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready   = (state == ST_LOAD);
        busy       = (state == ST_LOAD) || (state == ST_SETTLE);
        transfer   = ld_ready && ld_valid;
        load_start = (next_state == ST_LOAD) && (state != ST_LOAD);
    end

    // Registered outputs; core_run follows next_state so it drops in the
    // same cycle ld_ready rises on a reload from RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_run     <= 1'b0;
            done         <= 1'b0;
            word_cnt     <= '0;
            checksum     <= '0;
            err_overflow <= 1'b0;
        end else begin
            imem_we  <= transfer;
            core_run <= (next_state == ST_RUN);
            if (transfer) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= ld_data;
            end
            if (load_start) begin
                word_cnt     <= '0;
                checksum     <= '0;
                done         <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                if (transfer) begin
                    word_cnt <= word_cnt + CNT_ONE;
                    checksum <= checksum + CSUM_W'(ld_data);
                end
                if (state == ST_SETTLE) done <= 1'b1;
                if (next_state == ST_ERR) err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: a table of per-cycle vectors plus
// hand-written overflow and asynchronous-reset sequences.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        busy;
    logic        done;
    logic [7:0]  word_cnt;
    logic [31:0] checksum;
    logic        err_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        load_req;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        ld_last;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_we;
        logic [6:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_run;
        logic        exp_done;
        logic [7:0]  exp_cnt;
        logic [31:0] exp_csum;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    imem_boot_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_req     (load_req),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .busy         (busy),
        .done         (done),
        .word_cnt     (word_cnt),
        .checksum     (checksum),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic lr, input logic v, input logic [31:0] d,
                                input logic l, input logic rdy, input logic bsy,
                                input logic we, input logic [6:0] a, input logic [31:0] wd,
                                input logic run, input logic dn, input logic [7:0] cnt,
                                input logic [31:0] cs, input logic err);
        vec_t r;
        r.load_req = lr;   r.ld_valid = v;    r.ld_data = d;    r.ld_last = l;
        r.exp_ready = rdy; r.exp_busy = bsy;  r.exp_we = we;    r.exp_addr = a;
        r.exp_wdata = wd;  r.exp_run = run;   r.exp_done = dn;  r.exp_cnt = cnt;
        r.exp_csum = cs;   r.exp_err = err;
        return r;
    endfunction

    // Drives one cycle of inputs at a falling edge and returns at the next
    // falling edge, after the rising edge that consumed them.
    task automatic applyStimulus(input logic lr, input logic v, input logic [31:0] d,
                                 input logic l);
        load_req = lr;
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ld_ready"}, 32'(ld_ready), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".imem_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, ".imem_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, ".core_run"}, 32'(core_run), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".word_cnt"}, 32'(word_cnt), 32'd0);
        checkOutput({tag, ".checksum"}, checksum, 32'd0);
        checkOutput({tag, ".err_overflow"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        // Load 4 words with a host gap, idle in RUN, reload one word, then abort.
        vecs.push_back(mk(1,0,32'h0,0,        1,1,0,7'd0,32'h0,        0,0,8'd0,32'h0,0));
        vecs.push_back(mk(1,1,32'h00000013,0, 1,1,1,7'd0,32'h00000013, 0,0,8'd1,32'h00000013,0));
        vecs.push_back(mk(1,1,32'h00100093,0, 1,1,1,7'd1,32'h00100093, 0,0,8'd2,32'h001000A6,0));
        vecs.push_back(mk(1,0,32'hFFFFFFFF,1, 1,1,0,7'd0,32'h0,        0,0,8'd2,32'h001000A6,0));
        vecs.push_back(mk(1,1,32'h00200113,0, 1,1,1,7'd2,32'h00200113, 0,0,8'd3,32'h003001B9,0));
        vecs.push_back(mk(1,1,32'h00000063,1, 0,1,1,7'd3,32'h00000063, 0,0,8'd4,32'h0030021C,0));
        vecs.push_back(mk(1,0,32'h0,0,        0,0,0,7'd0,32'h0,        1,1,8'd4,32'h0030021C,0));
        vecs.push_back(mk(1,1,32'hBAD0BAD0,1, 0,0,0,7'd0,32'h0,        1,1,8'd4,32'h0030021C,0));
        vecs.push_back(mk(0,0,32'h0,0,        0,0,0,7'd0,32'h0,        1,1,8'd4,32'h0030021C,0));
        vecs.push_back(mk(1,0,32'h0,0,        1,1,0,7'd0,32'h0,        0,0,8'd0,32'h0,0));
        vecs.push_back(mk(1,1,32'hDEADBEEF,1, 0,1,1,7'd0,32'hDEADBEEF, 0,0,8'd1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,0,32'h0,0,        0,0,0,7'd0,32'h0,        1,1,8'd1,32'hDEADBEEF,0));
        vecs.push_back(mk(0,0,32'h0,0,        0,0,0,7'd0,32'h0,        1,1,8'd1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,0,32'h0,0,        1,1,0,7'd0,32'h0,        0,0,8'd0,32'h0,0));
        vecs.push_back(mk(1,1,32'h11111111,0, 1,1,1,7'd0,32'h11111111, 0,0,8'd1,32'h11111111,0));
        vecs.push_back(mk(1,1,32'h22222222,0, 1,1,1,7'd1,32'h22222222, 0,0,8'd2,32'h33333333,0));
        vecs.push_back(mk(0,0,32'h0,0,        0,0,0,7'd0,32'h0,        0,0,8'd2,32'h33333333,0));
        vecs.push_back(mk(0,1,32'h44444444,1, 0,0,0,7'd0,32'h0,        0,0,8'd2,32'h33333333,0));

        rst_n    = 1'b0;
        load_req = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load_req, vecs[i].ld_valid, vecs[i].ld_data, vecs[i].ld_last);
            checkOutput($sformatf("v%0d.ld_ready", i), 32'(ld_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d.imem_we", i), 32'(imem_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                checkOutput($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
                checkOutput($sformatf("v%0d.imem_wdata", i), imem_wdata, vecs[i].exp_wdata);
            end
            checkOutput($sformatf("v%0d.core_run", i), 32'(core_run), 32'(vecs[i].exp_run));
            checkOutput($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].exp_done));
            checkOutput($sformatf("v%0d.word_cnt", i), 32'(word_cnt), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("v%0d.checksum", i), checksum, vecs[i].exp_csum);
            checkOutput($sformatf("v%0d.err_overflow", i), 32'(err_overflow), 32'(vecs[i].exp_err));
        end

        // Overflow: 128 words (values 1..128) with no ld_last.
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("ovf.start_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1, 1, 32'(i + 1), 0);
            checkOutput($sformatf("ovf%0d.imem_we", i), 32'(imem_we), 32'd1);
            checkOutput($sformatf("ovf%0d.imem_addr", i), 32'(imem_addr), 32'(i));
            checkOutput($sformatf("ovf%0d.imem_wdata", i), imem_wdata, 32'(i + 1));
            checkOutput($sformatf("ovf%0d.ld_ready", i), 32'(ld_ready), (i < 127) ? 32'd1 : 32'd0);
            checkOutput($sformatf("ovf%0d.err_overflow", i), 32'(err_overflow), (i < 127) ? 32'd0 : 32'd1);
            checkOutput($sformatf("ovf%0d.core_run", i), 32'(core_run), 32'd0);
        end
        applyStimulus(1, 1, 32'h77, 1);
        checkOutput("err.imem_we", 32'(imem_we), 32'd0);
        checkOutput("err.busy", 32'(busy), 32'd0);
        checkOutput("err.core_run", 32'(core_run), 32'd0);
        checkOutput("err.word_cnt", 32'(word_cnt), 32'd128);
        checkOutput("err.checksum", checksum, 32'h00002040);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("err.hold", 32'(err_overflow), 32'd1);
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("err.clear", 32'(err_overflow), 32'd0);
        checkOutput("err.reload_ready", 32'(ld_ready), 32'd1);
        checkOutput("err.reload_cnt", 32'(word_cnt), 32'd0);
        applyStimulus(1, 1, 32'hCAFEF00D, 1);
        checkOutput("err.reload_addr", 32'(imem_addr), 32'd0);
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("err.reload_done", 32'(done), 32'd1);
        checkOutput("err.reload_run", 32'(core_run), 32'd1);
        checkOutput("err.reload_csum", checksum, 32'hCAFEF00D);

        // Asynchronous reset between clock edges in the middle of a load.
        applyStimulus(0, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(1, 1, 32'h55, 0);
        applyStimulus(1, 1, 32'h66, 0);
        checkOutput("pre_rst.word_cnt", 32'(word_cnt), 32'd2);
        ld_data = 32'h99;
        #2 rst_n = 1'b0;
        #1 checkResetValues("async_rst");
        @(posedge clk);
        #1 checkOutput("rst_held.imem_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 0);
        checkResetValues("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
